dijkstra_controller: RTL
========================

Name: dijkstra_controller

Overview:
- FSM that runs single-source shortest path over the PriorityQueue distance store and an external adjacency (edge-weight) memory.
- Owns the visited/predecessor state and drives the queue's prev_vector_flattened, set/get and index ports.
- Each iteration selects the queue's min unvisited node, then scans all neighbours and relaxes them.
- Sits between the top-level start/done handshake and the PriorityQueue plus edge RAM.

Parameters:
MAX_NODES, `DEFAULT_MAX_NODES, node count; must satisfy MAX_NODES <= `UNVISITED.
INDEX_WIDTH, `DEFAULT_INDEX_WIDTH, node index width.
VALUE_WIDTH, `DEFAULT_VALUE_WIDTH, distance/weight width; `INFINITY means unreachable or no edge.

Ports:
clock  in  1  single clock, posedge.
reset  in  1  synchronous, active-low.
start  in  1  one-cycle pulse; accepted only in IDLE.
source  in  INDEX_WIDTH  source node, sampled when start is accepted.
target  in  INDEX_WIDTH  early-exit node; used only with the optional feature.
busy  out  1  high from start acceptance until DONE.
done  out  1  level; high in DONE, cleared by the next accepted start.
edge_rd_en  out  1  edge RAM read strobe.
edge_rd_src  out  INDEX_WIDTH  edge row (u).
edge_rd_dst  out  INDEX_WIDTH  edge column (v).
edge_weight  in  VALUE_WIDTH  weight(u,v), valid the cycle after edge_rd_en (1-cycle latency).
pq_reset  out  1  active-high queue init strobe.
pq_set_en  out  1  queue write enable.
pq_index  out  INDEX_WIDTH  queue access index.
pq_wdata  out  VALUE_WIDTH  queue write value; the top level joins pq_wdata/pq_rdata onto the queue's inout value.
pq_rdata  in  VALUE_WIDTH  queue read value (combinational from pq_index).
pq_min_index  in  INDEX_WIDTH  queue min unvisited node.
pq_min_value  in  VALUE_WIDTH  queue min distance.
prev_vector_flattened  out  INDEX_WIDTH*MAX_NODES  entry j = pred[j] if visited[j], else `UNVISITED.

Behaviour:
- Reset (reset==0 at posedge), including mid-run:
  - state=IDLE; visited all 0; pred all 0.
  - busy=0, done=0; all strobes 0; prev vector all `UNVISITED.
- IDLE:
  - start accepted only if source < MAX_NODES; otherwise ignored and remains in IDLE.
  - On accept: latch source; clear visited and done; go to INIT.
- INIT (1 cycle):
  - pq_reset=1, pq_index=source (queue sets dist[source]=0, others `INFINITY).
  - Set pred[source]=source; go to SELECT.
- SELECT (1 cycle):
  - If visited count == MAX_NODES, or pq_min_value == `INFINITY → DONE.
  - Else u=pq_min_index, du=pq_min_value; set visited[u]; pred[u] is unchanged (already written). v=0; go to EDGE_REQ.
- EDGE_REQ:
  - If v == u or visited[v]: skip v (1 cycle, no read).
  - Otherwise: edge_rd_en=1, src=u, dst=v; go to EDGE_WAIT.
- EDGE_WAIT (1 cycle): pq_index=v; sum = du + edge_weight computed at VALUE_WIDTH+1 bits.
  - Relax when edge_weight != `INFINITY, sum < `INFINITY and sum < pq_rdata.
  - On relax: pq_set_en=1, pq_wdata=sum[VALUE_WIDTH-1:0]; pred[v]=u.
  - Then advance v.
- Advance v:
  - After v == MAX_NODES-1 → SELECT; otherwise → EDGE_REQ.
  - v must not wrap past MAX_NODES-1.
- Cost: 1 cycle per skipped neighbour, 2 per scanned neighbour, plus 1 per SELECT. Worst case about MAX_NODES*(2*MAX_NODES+1)+2 cycles.
- Visibility: visited[u] becomes visible on prev_vector_flattened the cycle after SELECT, so u is excluded from the next min.
- DONE:
  - busy=0, done=1; prev vector holds the final tree.
  - Unreachable nodes stay `UNVISITED.
  - start → INIT (treated as from IDLE).
- start while busy: ignored.
- pq_set_en and pq_reset: never asserted outside EDGE_WAIT and INIT respectively.

Optional Feature:
DIJKSTRA_EARLY_EXIT_EN:
- Defined: target latched with source. SELECT goes to DONE in the cycle after the cycle where u == target is marked visited. Remaining nodes keep queue-side distances; they are not finalised.
- Undefined: target is ignored and the run completes normally.

Decomposition:
- Shared package (constants.v): `UNVISITED, `INFINITY, `DEFAULT_* widths, and FSM state encodings (IDLE, INIT, SELECT, EDGE_REQ, EDGE_WAIT, DONE).
- One sub-module, dijkstra_relax: pure combinational widened add, saturation and compare. Inputs du, weight, cur; outputs relax and new_dist.
- The FSM, visited/pred registers and the prev-vector flattening stay in the controller.

Test Plan:
- Graph (symmetric, other edges `INFINITY): 0-1 w4, 0-2 w1, 2-1 w2, 1-3 w5. Bench MAX_NODES=4; source=0; start → queue dist {0,3,1,8}, prev {0,2,0,1}, done high, busy low.
- Same graph with node 3 isolated → prev[3]=`UNVISITED, dist[3]=`INFINITY, done asserted after the SELECT that sees `INFINITY.
- Edge 0-1 weight `INFINITY-1 and du=2 → sum saturates; no relax, no pq_set_en in that EDGE_WAIT.
- reset low mid-EDGE_WAIT → next cycle IDLE, prev all `UNVISITED, busy=0. A new start(source=2) then yields dist {1,2,0,7}.
- start while busy, or start with source=MAX_NODES → ignored; state and outputs unchanged.
- With DIJKSTRA_EARLY_EXIT_EN, target=2, source=0 → done after node 2 is visited; visited set is exactly {0,2}.

Source files
------------

// File: rtl/dijkstra_controller_pkg.sv
// rtl/dijkstra_controller_pkg.sv - shared widths, sentinels and FSM state encoding for the shortest-path controller
package dijkstra_controller_pkg;

    localparam int DEFAULT_MAX_NODES   = 8;
    localparam int DEFAULT_INDEX_WIDTH = 4;
    localparam int DEFAULT_VALUE_WIDTH = 8;

    // Sentinels are all-ones at whatever width is in use.
    localparam logic [DEFAULT_INDEX_WIDTH-1:0] UNVISITED = '1;
    localparam logic [DEFAULT_VALUE_WIDTH-1:0] INFINITY  = '1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT      = 3'd1,
        ST_SELECT    = 3'd2,
        ST_EDGE_REQ  = 3'd3,
        ST_EDGE_WAIT = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

endpackage

// File: rtl/dijkstra_controller_if.sv
// rtl/dijkstra_controller_if.sv - edge RAM and priority-queue access bundle between controller and storage
interface dijkstra_controller_if #(
    parameter int INDEX_WIDTH = 4,
    parameter int VALUE_WIDTH = 8
);
    logic                   edge_rd_en;
    logic [INDEX_WIDTH-1:0] edge_rd_src;
    logic [INDEX_WIDTH-1:0] edge_rd_dst;
    logic [VALUE_WIDTH-1:0] edge_weight;
    logic                   pq_reset;
    logic                   pq_set_en;
    logic [INDEX_WIDTH-1:0] pq_index;
    logic [VALUE_WIDTH-1:0] pq_wdata;
    logic [VALUE_WIDTH-1:0] pq_rdata;
    logic [INDEX_WIDTH-1:0] pq_min_index;
    logic [VALUE_WIDTH-1:0] pq_min_value;

    modport master (
        output edge_rd_en, edge_rd_src, edge_rd_dst, pq_reset, pq_set_en, pq_index, pq_wdata,
        input  edge_weight, pq_rdata, pq_min_index, pq_min_value
    );

    modport slave (
        input  edge_rd_en, edge_rd_src, edge_rd_dst, pq_reset, pq_set_en, pq_index, pq_wdata,
        output edge_weight, pq_rdata, pq_min_index, pq_min_value
    );
endinterface

// File: rtl/dijkstra_controller_relax.sv
// rtl/dijkstra_controller_relax.sv - combinational edge relaxation: widened add, saturation and compare
module dijkstra_relax #(
    parameter int VALUE_WIDTH = 8
) (
    input  logic [VALUE_WIDTH-1:0] du,
    input  logic [VALUE_WIDTH-1:0] weight,
    input  logic [VALUE_WIDTH-1:0] cur,
    output logic                   relax,
    output logic [VALUE_WIDTH-1:0] new_dist
);
    localparam logic [VALUE_WIDTH:0] INF_WIDE = {1'b0, {VALUE_WIDTH{1'b1}}};

    logic [VALUE_WIDTH:0] sum;

    // The extra bit keeps an overflowing sum from wrapping into a small, bogus distance.
    always_comb begin
        sum      = {1'b0, du} + {1'b0, weight};
        relax    = ({1'b0, weight} != INF_WIDE) && (sum < INF_WIDE) && (sum < {1'b0, cur});
        new_dist = (sum >= INF_WIDE) ? INF_WIDE[VALUE_WIDTH-1:0] : sum[VALUE_WIDTH-1:0];
    end
endmodule

// File: rtl/dijkstra_controller.sv
// rtl/dijkstra_controller.sv - single-source shortest-path FSM over a priority queue and edge RAM
// Optional early exit at the target node: DIJKSTRA_EARLY_EXIT_EN
module dijkstra_controller
    import dijkstra_controller_pkg::*;
#(
    parameter int MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [INDEX_WIDTH-1:0]           source,
    input  logic [INDEX_WIDTH-1:0]           target,
    output logic                             busy,
    output logic                             done,
    dijkstra_controller_if.master            bus,
    output logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened
);
    localparam logic [INDEX_WIDTH-1:0] UNVISITED_W = {INDEX_WIDTH{1'b1}};
    localparam logic [VALUE_WIDTH-1:0] INFINITY_W  = {VALUE_WIDTH{1'b1}};
    localparam logic [INDEX_WIDTH-1:0] LAST_NODE   = INDEX_WIDTH'(MAX_NODES - 1);
    localparam int                     CW          = $clog2(MAX_NODES + 1);
    localparam logic [CW-1:0]          NODE_COUNT  = CW'(MAX_NODES);

    state_e                 state_q, state_d;
    logic [MAX_NODES-1:0]   visited_q, visited_d;
    logic [INDEX_WIDTH-1:0] pred_q [MAX_NODES];
    logic [INDEX_WIDTH-1:0] pred_d [MAX_NODES];
    logic [INDEX_WIDTH-1:0] src_q, src_d;
    logic [INDEX_WIDTH-1:0] u_q, u_d;
    logic [VALUE_WIDTH-1:0] du_q, du_d;
    logic [INDEX_WIDTH-1:0] v_q, v_d;
    logic [CW-1:0]          count_q, count_d;
`ifdef DIJKSTRA_EARLY_EXIT_EN
    logic [INDEX_WIDTH-1:0] target_q, target_d;
`else
    logic                   target_unused;
    assign target_unused = ^target;
`endif

    logic                   relax;
    logic [VALUE_WIDTH-1:0] new_dist;
    logic                   start_ok;
    logic                   v_visited;
    logic                   advance;

    dijkstra_relax #(.VALUE_WIDTH(VALUE_WIDTH)) u_relax (
        .du      (du_q),
        .weight  (bus.edge_weight),
        .cur     (bus.pq_rdata),
        .relax   (relax),
        .new_dist(new_dist)
    );

    always_comb begin
        state_d   = state_q;
        visited_d = visited_q;
        pred_d    = pred_q;
        src_d     = src_q;
        u_d       = u_q;
        du_d      = du_q;
        v_d       = v_q;
        count_d   = count_q;
`ifdef DIJKSTRA_EARLY_EXIT_EN
        target_d  = target_q;
`endif
        bus.edge_rd_en  = 1'b0;
        bus.edge_rd_src = u_q;
        bus.edge_rd_dst = v_q;
        bus.pq_reset    = 1'b0;
        bus.pq_set_en   = 1'b0;
        bus.pq_index    = v_q;
        bus.pq_wdata    = new_dist;
        advance         = 1'b0;

        start_ok  = start && (source < INDEX_WIDTH'(MAX_NODES));
        v_visited = 1'b0;
        for (int j = 0; j < MAX_NODES; j++) begin
            if (v_q == INDEX_WIDTH'(j)) v_visited = visited_q[j];
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    src_d     = source;
`ifdef DIJKSTRA_EARLY_EXIT_EN
                    target_d  = target;
`endif
                    visited_d = '0;
                    count_d   = '0;
                    state_d   = ST_INIT;
                end
            end
            ST_INIT: begin
                bus.pq_reset = 1'b1;
                bus.pq_index = src_q;
                for (int j = 0; j < MAX_NODES; j++) begin
                    if (src_q == INDEX_WIDTH'(j)) pred_d[j] = src_q;
                end
                state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (count_q == NODE_COUNT || bus.pq_min_value == INFINITY_W) begin
                    state_d = ST_DONE;
                end else begin
                    u_d     = bus.pq_min_index;
                    du_d    = bus.pq_min_value;
                    count_d = count_q + CW'(1);
                    v_d     = '0;
                    for (int j = 0; j < MAX_NODES; j++) begin
                        if (bus.pq_min_index == INDEX_WIDTH'(j)) visited_d[j] = 1'b1;
                    end
                    state_d = ST_EDGE_REQ;
`ifdef DIJKSTRA_EARLY_EXIT_EN
                    if (bus.pq_min_index == target_q) state_d = ST_DONE;
`endif
                end
            end
            ST_EDGE_REQ: begin
                if (v_q == u_q || v_visited) begin
                    advance = 1'b1;
                end else begin
                    bus.edge_rd_en = 1'b1;
                    state_d        = ST_EDGE_WAIT;
                end
            end
            ST_EDGE_WAIT: begin
                if (relax) begin
                    bus.pq_set_en = 1'b1;
                    for (int j = 0; j < MAX_NODES; j++) begin
                        if (v_q == INDEX_WIDTH'(j)) pred_d[j] = u_q;
                    end
                end
                advance = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // v stops at the last node rather than wrapping back to zero.
        if (advance) begin
            if (v_q == LAST_NODE) begin
                state_d = ST_SELECT;
            end else begin
                v_d     = v_q + INDEX_WIDTH'(1);
                state_d = ST_EDGE_REQ;
            end
        end

        busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done = (state_q == ST_DONE);
    end

    always_comb begin
        prev_vector_flattened = '0;
        for (int j = 0; j < MAX_NODES; j++) begin
            prev_vector_flattened[j*INDEX_WIDTH +: INDEX_WIDTH] = visited_q[j] ? pred_q[j] : UNVISITED_W;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            visited_q <= '0;
            pred_q    <= '{default: '0};
            src_q     <= '0;
            u_q       <= '0;
            du_q      <= '0;
            v_q       <= '0;
            count_q   <= '0;
`ifdef DIJKSTRA_EARLY_EXIT_EN
            target_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            visited_q <= visited_d;
            pred_q    <= pred_d;
            src_q     <= src_d;
            u_q       <= u_d;
            du_q      <= du_d;
            v_q       <= v_d;
            count_q   <= count_d;
`ifdef DIJKSTRA_EARLY_EXIT_EN
            target_q  <= target_d;
`endif
        end
    end
endmodule
